dma_pcie_axis_cq_buf: RTL and testbench
=======================================

// Module: dma_pcie_axis_cq_buf
// PURPOSE
// - Parametrised CQ (completer request) AXI-stream buffer between the PCIe/CPM CQ source and the DMA completer logic.
// - Registered, replicated tready toward the source; FIFO of DEPTH beats; cut-through or store-and-forward (PKT_MODE) egress.
// - Store-and-forward never deadlocks: a packet longer than DEPTH drains cut-through.
// PARAMETERS
// - DATA_WIDTH   512  tdata width; tkeep is DATA_WIDTH/32 (dword enables)
// - USER_WIDTH   183  tuser width
// - TREADY_WIDTH 22   replicated s_cq_tready bits, all identical
// - DEPTH        16   FIFO beats; power of 2, >= 4
// - PKT_MODE     0    0 = cut-through; 1 = store-and-forward
// PORTS
// - user_clk        in  1               sole clock
// - user_reset_n    in  1               synchronous, active-low reset
// - s_cq_tdata      in  DATA_WIDTH      ingress data
// - s_cq_tuser      in  USER_WIDTH      ingress sideband
// - s_cq_tlast      in  1               ingress end of packet
// - s_cq_tkeep      in  DATA_WIDTH/32   ingress dword enables
// - s_cq_tvalid     in  1               ingress valid
// - s_cq_tready     out TREADY_WIDTH    registered ready, replicated
// - m_cq_tdata/tuser/tlast/tkeep  out   egress beat, widths as ingress
// - m_cq_tvalid     out 1               egress valid
// - m_cq_tready     in  1               egress ready
// - occupancy       out $clog2(DEPTH)+1 beats stored
// - perf_beat_cnt   out 32              accepted ingress beats (see CONFIGURATION)
// - perf_pkt_cnt    out 32              accepted ingress tlast beats (see CONFIGURATION)
// BEHAVIOUR
// - Reset (user_reset_n=0 at edge): pointers, occupancy, pkt_cnt = 0; s_cq_tready = 0; m_cq_tvalid = 0; state = ST_STORE; perf counters = 0. Reset mid-packet discards all stored beats; no partial flush.
// - First cycle after reset release: s_cq_tready = all ones.
// - Write: wr = s_cq_tvalid & s_cq_tready[0]. Read: rd = m_cq_tvalid & m_cq_tready.
// - occupancy_next = occupancy + wr - rd; simultaneous wr&rd leaves it unchanged, legal even when full.
// - s_cq_tready <= {TREADY_WIDTH{occupancy_next < DEPTH}}; registered, exact, no overflow possible.
// - Pointers $clog2(DEPTH) bits, wrap naturally; full = occupancy==DEPTH, empty = occupancy==0.
// - Egress is first-word-fall-through from storage; beat written in cycle N presents on m_cq_* in cycle N+1 (PKT_MODE=0).
// - m_cq_* data holds stable while m_cq_tvalid & !m_cq_tready (AXIS rule).
// - pkt_cnt (complete packets stored): +1 on wr&tlast, -1 on rd&tlast, unchanged on both.
// - PKT_MODE=0: m_cq_tvalid = !empty.
// - PKT_MODE=1: FSM
//   ST_STORE: m_cq_tvalid = !empty & (pkt_cnt>0); if full & pkt_cnt==0 -> ST_FLUSH.
//   ST_FLUSH: m_cq_tvalid = !empty; on rd & m_cq_tlast -> ST_STORE.
//   Tail latency in ST_STORE: tlast written cycle N -> m_cq_tvalid cycle N+1.
// CONFIGURATION
// - Macro DMA_PCIE_CQ_BUF_PERF_EN defined: perf_beat_cnt += wr, perf_pkt_cnt += wr&tlast; 32-bit, wrap on overflow, clear on reset.
// - Macro undefined: counters not built; perf_beat_cnt, perf_pkt_cnt tied to 0; ports remain.
// STRUCTURE
// - Package dma_pcie_cq_buf_pkg: CQ_DATA_W=512, CQ_USER_W=183, CQ_TREADY_W=22 defaults; enum cq_buf_state_e {ST_STORE, ST_FLUSH}.
// - Sub-module dma_pcie_cq_buf_mem: register-array storage + wr/rd pointers, FWFT read, packs {tuser,tlast,tkeep,tdata}.
// - Top: ready register, occupancy/pkt_cnt, FSM, perf counters.
// TESTING
// - Reset: hold user_reset_n=0 3 cycles -> s_cq_tready=0, m_cq_tvalid=0, occupancy=0; release -> tready=22'h3FFFFF next cycle.
// - Fill (PKT_MODE=0, DEPTH=16): 16 beats, m_cq_tready=0 -> tready drops cycle after 16th write; occupancy=16; no 17th accepted.
// - Full + simultaneous wr/rd: occupancy=15, wr&rd each cycle for 20 cycles -> occupancy stays 15, output order matches input.
// - Store-and-forward (PKT_MODE=1): 3-beat packet -> m_cq_tvalid=0 until cycle after tlast write, then 3 beats in order.
// - Oversize (PKT_MODE=1, DEPTH=16): 40-beat packet -> ST_FLUSH at full, all 40 beats delivered, ST_STORE after tlast read.
// - Perf (macro defined): 5 packets of 2 beats, random backpressure -> perf_beat_cnt=10, perf_pkt_cnt=5; undefined -> both 0.

Source files
------------

// File: rtl/dma_pcie_cq_buf_pkg.sv
// -----------------------------------------------------------------------------
// dma_pcie_cq_buf_pkg
// Shared defaults and types for the PCIe CQ (completer request) stream buffer.
//   CQ_DATA_W   : default tdata width (tkeep is one bit per dword)
//   CQ_USER_W   : default tuser width
//   CQ_TREADY_W : default number of replicated s_cq_tready bits
//   CQ_DEPTH    : default FIFO depth in beats
//   cq_buf_state_e : store-and-forward egress state
// -----------------------------------------------------------------------------
package dma_pcie_cq_buf_pkg;

  localparam int CQ_DATA_W   = 512;
  localparam int CQ_USER_W   = 183;
  localparam int CQ_TREADY_W = 22;
  localparam int CQ_DEPTH    = 16;

  // ST_STORE holds partial packets back; ST_FLUSH drains a packet that
  // cannot fit in the FIFO as cut-through.
  typedef enum logic [0:0] {
    ST_STORE = 1'b0,
    ST_FLUSH = 1'b1
  } cq_buf_state_e;

  // One tkeep bit per 32-bit dword of tdata.
  function automatic int cq_keep_w(input int data_w);
    return data_w / 32;
  endfunction

endpackage

// File: rtl/dma_pcie_cq_buf_mem.sv
// -----------------------------------------------------------------------------
// dma_pcie_cq_buf_mem
// Register-array beat storage with wrapping write/read pointers and a
// first-word-fall-through read port. Each entry packs {tuser,tlast,tkeep,tdata}.
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset (pointers only)
//   wr_i                   : store the ingress beat at the write pointer
//   tdata_i/tuser_i/...    : ingress beat fields
//   rd_i                   : advance the read pointer (head beat consumed)
//   tdata_o/tuser_o/...    : head beat fields, valid whenever storage is non-empty
// The caller guarantees no write when full and no read when empty.
// -----------------------------------------------------------------------------
module dma_pcie_cq_buf_mem
  import dma_pcie_cq_buf_pkg::*;
#(
  parameter int DATA_WIDTH = CQ_DATA_W,
  parameter int USER_WIDTH = CQ_USER_W,
  parameter int DEPTH      = CQ_DEPTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_i,
  input  logic [DATA_WIDTH-1:0]            tdata_i,
  input  logic [USER_WIDTH-1:0]            tuser_i,
  input  logic                             tlast_i,
  input  logic [cq_keep_w(DATA_WIDTH)-1:0] tkeep_i,
  input  logic                             rd_i,
  output logic [DATA_WIDTH-1:0]            tdata_o,
  output logic [USER_WIDTH-1:0]            tuser_o,
  output logic                             tlast_o,
  output logic [cq_keep_w(DATA_WIDTH)-1:0] tkeep_o
);

  localparam int KEEP_W  = cq_keep_w(DATA_WIDTH);
  localparam int ENTRY_W = USER_WIDTH + 1 + KEEP_W + DATA_WIDTH;
  localparam int PTR_W   = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;

  // Pointers are DEPTH-sized, so they wrap naturally.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_i) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // NOTE: the storage array is deliberately not reset; contents are only
  // visible once the pointers say a slot holds a valid beat, and leaving the
  // reset off keeps it a plain register file.
  always_ff @(posedge clk) begin
    if (wr_i) mem_q[wr_ptr_q] <= {tuser_i, tlast_i, tkeep_i, tdata_i};
  end

  assign {tuser_o, tlast_o, tkeep_o, tdata_o} = mem_q[rd_ptr_q];

endmodule

// File: rtl/dma_pcie_axis_cq_buf.sv
// -----------------------------------------------------------------------------
// dma_pcie_axis_cq_buf
// AXI-stream buffer between the PCIe CQ source and the DMA completer logic.
// A registered, replicated s_cq_tready fronts a DEPTH-beat FWFT FIFO; egress is
// cut-through (PKT_MODE=0) or store-and-forward (PKT_MODE=1). In
// store-and-forward a packet longer than DEPTH fills the FIFO with no complete
// packet inside; the buffer then drains that packet cut-through (ST_FLUSH).
// Ports:
//   user_clk, user_reset_n       : clock, synchronous active-low reset
//   s_cq_t*                      : ingress stream (tready replicated, registered)
//   m_cq_t*                      : egress stream
//   occupancy                    : beats currently stored
//   perf_beat_cnt, perf_pkt_cnt  : accepted ingress beats / tlast beats
// Optional feature: define DMA_PCIE_CQ_BUF_PERF_EN to build the perf counters;
// otherwise both perf outputs are tied to zero.
// -----------------------------------------------------------------------------
module dma_pcie_axis_cq_buf
  import dma_pcie_cq_buf_pkg::*;
#(
  parameter int DATA_WIDTH   = CQ_DATA_W,
  parameter int USER_WIDTH   = CQ_USER_W,
  parameter int TREADY_WIDTH = CQ_TREADY_W,
  parameter int DEPTH        = CQ_DEPTH,
  parameter int PKT_MODE     = 0
) (
  input  logic                             user_clk,
  input  logic                             user_reset_n,
  input  logic [DATA_WIDTH-1:0]            s_cq_tdata,
  input  logic [USER_WIDTH-1:0]            s_cq_tuser,
  input  logic                             s_cq_tlast,
  input  logic [cq_keep_w(DATA_WIDTH)-1:0] s_cq_tkeep,
  input  logic                             s_cq_tvalid,
  output logic [TREADY_WIDTH-1:0]          s_cq_tready,
  output logic [DATA_WIDTH-1:0]            m_cq_tdata,
  output logic [USER_WIDTH-1:0]            m_cq_tuser,
  output logic                             m_cq_tlast,
  output logic [cq_keep_w(DATA_WIDTH)-1:0] m_cq_tkeep,
  output logic                             m_cq_tvalid,
  input  logic                             m_cq_tready,
  output logic [$clog2(DEPTH):0]           occupancy,
  output logic [31:0]                      perf_beat_cnt,
  output logic [31:0]                      perf_pkt_cnt
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic [TREADY_WIDTH-1:0] tready_q;
  logic [OCC_W-1:0]        occ_q, occ_d;
  logic [OCC_W-1:0]        pkt_q, pkt_d;
  cq_buf_state_e           state_q, state_d;
  logic                    wr, rd, empty, full;

  assign wr    = s_cq_tvalid & tready_q[0];
  assign rd    = m_cq_tvalid & m_cq_tready;
  assign empty = (occ_q == '0);
  assign full  = (occ_q == OCC_W'(DEPTH));

  dma_pcie_cq_buf_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .USER_WIDTH (USER_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (user_clk),
    .rst_n   (user_reset_n),
    .wr_i    (wr),
    .tdata_i (s_cq_tdata),
    .tuser_i (s_cq_tuser),
    .tlast_i (s_cq_tlast),
    .tkeep_i (s_cq_tkeep),
    .rd_i    (rd),
    .tdata_o (m_cq_tdata),
    .tuser_o (m_cq_tuser),
    .tlast_o (m_cq_tlast),
    .tkeep_o (m_cq_tkeep)
  );

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    occ_d = occ_q;
    pkt_d = pkt_q;
    case ({wr, rd})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: ;
    endcase
    case ({wr & s_cq_tlast, rd & m_cq_tlast})
      2'b10:   pkt_d = pkt_q + OCC_W'(1);
      2'b01:   pkt_d = pkt_q - OCC_W'(1);
      default: ;
    endcase
  end

  // Egress valid and store-and-forward FSM. The FLUSH exit is written in terms
  // of the FIFO state rather than rd to keep m_cq_tvalid out of its own cone.
  always_comb begin
    state_d     = state_q;
    m_cq_tvalid = !empty;
    if (PKT_MODE != 0) begin
      case (state_q)
        ST_STORE: begin
          m_cq_tvalid = !empty && (pkt_q != '0);
          if (full && (pkt_q == '0)) state_d = ST_FLUSH;
        end
        ST_FLUSH: begin
          if (!empty && m_cq_tready && m_cq_tlast) state_d = ST_STORE;
        end
        default: state_d = ST_STORE;
      endcase
    end
  end

  // Ready is computed from next-cycle occupancy, so it is exact: it drops in
  // the cycle after the write that fills the FIFO and never admits overflow.
  always_ff @(posedge user_clk) begin
    if (!user_reset_n) begin
      tready_q <= '0;
      occ_q    <= '0;
      pkt_q    <= '0;
      state_q  <= ST_STORE;
    end else begin
      tready_q <= {TREADY_WIDTH{occ_d < OCC_W'(DEPTH)}};
      occ_q    <= occ_d;
      pkt_q    <= pkt_d;
      state_q  <= state_d;
    end
  end

  assign s_cq_tready = tready_q;
  assign occupancy   = occ_q;

`ifdef DMA_PCIE_CQ_BUF_PERF_EN
  logic [31:0] perf_beat_q;
  logic [31:0] perf_pkt_q;

  always_ff @(posedge user_clk) begin
    if (!user_reset_n) begin
      perf_beat_q <= '0;
      perf_pkt_q  <= '0;
    end else begin
      if (wr)              perf_beat_q <= perf_beat_q + 32'd1;
      if (wr & s_cq_tlast) perf_pkt_q  <= perf_pkt_q + 32'd1;
    end
  end

  assign perf_beat_cnt = perf_beat_q;
  assign perf_pkt_cnt  = perf_pkt_q;
`else
  assign perf_beat_cnt = '0;
  assign perf_pkt_cnt  = '0;
`endif

endmodule

// File: tb/tb_dma_pcie_axis_cq_buf.sv
// -----------------------------------------------------------------------------
// tb_dma_pcie_axis_cq_buf
// Directed bench for the CQ stream buffer. Two instances share clock and reset:
// u_ct (cut-through, PKT_MODE=0) and u_sf (store-and-forward, PKT_MODE=1).
// Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_dma_pcie_axis_cq_buf;

  localparam int DW = 512;
  localparam int UW = 183;
  localparam int KW = 16;
  localparam int TW = 22;
  localparam int OW = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // cut-through instance signals
  logic [DW-1:0] s0_tdata, m0_tdata;
  logic [UW-1:0] s0_tuser, m0_tuser;
  logic [KW-1:0] s0_tkeep, m0_tkeep;
  logic          s0_tlast, s0_tvalid, m0_tlast, m0_tvalid, m0_tready;
  logic [TW-1:0] s0_tready;
  logic [OW-1:0] occ0;
  logic [31:0]   beats0, pkts0;

  // store-and-forward instance signals
  logic [DW-1:0] s1_tdata, m1_tdata;
  logic [UW-1:0] s1_tuser, m1_tuser;
  logic [KW-1:0] s1_tkeep, m1_tkeep;
  logic          s1_tlast, s1_tvalid, m1_tlast, m1_tvalid, m1_tready;
  logic [TW-1:0] s1_tready;
  logic [OW-1:0] occ1;
  logic [31:0]   beats1, pkts1;

  dma_pcie_axis_cq_buf #(.PKT_MODE(0)) u_ct (
    .user_clk      (clk),
    .user_reset_n  (rst_n),
    .s_cq_tdata    (s0_tdata),
    .s_cq_tuser    (s0_tuser),
    .s_cq_tlast    (s0_tlast),
    .s_cq_tkeep    (s0_tkeep),
    .s_cq_tvalid   (s0_tvalid),
    .s_cq_tready   (s0_tready),
    .m_cq_tdata    (m0_tdata),
    .m_cq_tuser    (m0_tuser),
    .m_cq_tlast    (m0_tlast),
    .m_cq_tkeep    (m0_tkeep),
    .m_cq_tvalid   (m0_tvalid),
    .m_cq_tready   (m0_tready),
    .occupancy     (occ0),
    .perf_beat_cnt (beats0),
    .perf_pkt_cnt  (pkts0)
  );

  dma_pcie_axis_cq_buf #(.PKT_MODE(1)) u_sf (
    .user_clk      (clk),
    .user_reset_n  (rst_n),
    .s_cq_tdata    (s1_tdata),
    .s_cq_tuser    (s1_tuser),
    .s_cq_tlast    (s1_tlast),
    .s_cq_tkeep    (s1_tkeep),
    .s_cq_tvalid   (s1_tvalid),
    .s_cq_tready   (s1_tready),
    .m_cq_tdata    (m1_tdata),
    .m_cq_tuser    (m1_tuser),
    .m_cq_tlast    (m1_tlast),
    .m_cq_tkeep    (m1_tkeep),
    .m_cq_tvalid   (m1_tvalid),
    .m_cq_tready   (m1_tready),
    .occupancy     (occ1),
    .perf_beat_cnt (beats1),
    .perf_pkt_cnt  (pkts1)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input int n);
    return {16{32'(n)}};
  endfunction

  function automatic logic [UW-1:0] beat_user(input int n);
    return UW'(n) + UW'(7);
  endfunction

  function automatic logic [KW-1:0] beat_keep(input int n);
    return KW'(n) | 16'h8000;
  endfunction

  int sent, rcvd;
  logic acc_in, acc_out;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    s0_tdata  = '0; s0_tuser = '0; s0_tkeep = '0; s0_tlast = 1'b0; s0_tvalid = 1'b0; m0_tready = 1'b0;
    s1_tdata  = '0; s1_tuser = '0; s1_tkeep = '0; s1_tlast = 1'b0; s1_tvalid = 1'b0; m1_tready = 1'b0;

    // ---- reset: 3 cycles held low ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tready", DW'(s0_tready), DW'(0));
    check("rst_tvalid", DW'(m0_tvalid), DW'(0));
    check("rst_occ", DW'(occ0), DW'(0));
    check("rst_sf_tvalid", DW'(m1_tvalid), DW'(0));
    rst_n = 1'b1;
    check("rel_tready_before_edge", DW'(s0_tready), DW'(0));
    @(negedge clk);
    check("rel_tready", DW'(s0_tready), DW'(22'h3FFFFF));
    check("rel_sf_tready", DW'(s1_tready), DW'(22'h3FFFFF));

    // ---- perf: 5 packets of 2 beats, random egress backpressure ----
    sent = 0; rcvd = 0;
    for (int cyc = 0; cyc < 300 && rcvd < 10; cyc++) begin
      s0_tvalid = (sent < 10);
      s0_tdata  = beat_data(sent);
      s0_tuser  = beat_user(sent);
      s0_tkeep  = beat_keep(sent);
      s0_tlast  = (sent % 2 == 1);
      m0_tready = 1'($urandom_range(0, 1));
      acc_in    = s0_tvalid && s0_tready[0];
      acc_out   = m0_tvalid && m0_tready;
      if (acc_out) begin
        check("perf_out_data", m0_tdata, beat_data(rcvd));
        check("perf_out_last", DW'(m0_tlast), DW'(rcvd % 2 == 1));
        rcvd++;
      end
      if (acc_in) sent++;
      @(negedge clk);
    end
    s0_tvalid = 1'b0; s0_tlast = 1'b0; m0_tready = 1'b0;
    check("perf_all_received", DW'(rcvd), DW'(10));
`ifdef DMA_PCIE_CQ_BUF_PERF_EN
    check("perf_beat_cnt", DW'(beats0), DW'(10));
    check("perf_pkt_cnt", DW'(pkts0), DW'(5));
`else
    check("perf_beat_cnt_off", DW'(beats0), DW'(0));
    check("perf_pkt_cnt_off", DW'(pkts0), DW'(0));
`endif
    check("perf_occ_empty", DW'(occ0), DW'(0));

    // ---- fill: 20 offered beats, no egress; exactly 16 accepted ----
    sent = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      s0_tvalid = 1'b1;
      s0_tdata  = beat_data(100 + sent);
      s0_tuser  = beat_user(100 + sent);
      s0_tkeep  = beat_keep(100 + sent);
      if (s0_tready[0]) sent++;
      @(negedge clk);
    end
    s0_tvalid = 1'b0;
    check("fill_accepted", DW'(sent), DW'(16));
    check("fill_occ", DW'(occ0), DW'(16));
    check("fill_tready", DW'(s0_tready), DW'(0));
    check("fill_head_valid", DW'(m0_tvalid), DW'(1));
    check("fill_head_data", m0_tdata, beat_data(100));
    check("fill_head_user", DW'(m0_tuser), DW'(beat_user(100)));
    check("fill_head_keep", DW'(m0_tkeep), DW'(beat_keep(100)));

    // ---- drain one beat, then simultaneous wr/rd for 20 cycles at 15 ----
    m0_tready = 1'b1;
    @(negedge clk);
    check("drain1_occ", DW'(occ0), DW'(15));
    for (int i = 0; i < 20; i++) begin
      s0_tvalid = 1'b1;
      s0_tdata  = beat_data(116 + i);
      check("wr_rd_tready", DW'(s0_tready[0]), DW'(1));
      check("wr_rd_occ", DW'(occ0), DW'(15));
      check("wr_rd_data", m0_tdata, beat_data(101 + i));
      @(negedge clk);
    end
    s0_tvalid = 1'b0; m0_tready = 1'b0;
    check("wr_rd_occ_end", DW'(occ0), DW'(15));
    check("wr_rd_head_end", m0_tdata, beat_data(121));

    // ---- store-and-forward: 3-beat packet ----
    m1_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s1_tvalid = 1'b1;
      s1_tdata  = beat_data(200 + i);
      s1_tuser  = beat_user(200 + i);
      s1_tkeep  = beat_keep(200 + i);
      s1_tlast  = (i == 2);
      check("sf_hold_valid", DW'(m1_tvalid), DW'(0));
      @(negedge clk);
    end
    s1_tvalid = 1'b0; s1_tlast = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("sf_out_valid", DW'(m1_tvalid), DW'(1));
      check("sf_out_data", m1_tdata, beat_data(200 + i));
      check("sf_out_last", DW'(m1_tlast), DW'(i == 2));
      if (i == 0) begin
        check("sf_out_user", DW'(m1_tuser), DW'(beat_user(200)));
        check("sf_out_keep", DW'(m1_tkeep), DW'(beat_keep(200)));
      end
      @(negedge clk);
    end
    check("sf_done_valid", DW'(m1_tvalid), DW'(0));
    check("sf_done_occ", DW'(occ1), DW'(0));

    // ---- oversize: 40-beat packet with egress stalled until full ----
    m1_tready = 1'b0;
    sent = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      s1_tvalid = 1'b1;
      s1_tdata  = beat_data(300 + sent);
      s1_tlast  = 1'b0;
      check("ovr_fill_valid", DW'(m1_tvalid), DW'(0));
      if (s1_tready[0]) sent++;
      @(negedge clk);
    end
    s1_tvalid = 1'b0;
    check("ovr_fill_sent", DW'(sent), DW'(16));
    check("ovr_full_occ", DW'(occ1), DW'(16));
    check("ovr_full_tready", DW'(s1_tready), DW'(0));
    check("ovr_full_valid", DW'(m1_tvalid), DW'(0));
    @(negedge clk);
    check("ovr_flush_valid", DW'(m1_tvalid), DW'(1));
    check("ovr_flush_head", m1_tdata, beat_data(300));
    rcvd = 0;
    for (int cyc = 0; cyc < 400 && rcvd < 40; cyc++) begin
      s1_tvalid = (sent < 40);
      s1_tdata  = beat_data(300 + sent);
      s1_tlast  = (sent == 39);
      m1_tready = 1'($urandom_range(0, 3) != 0);
      acc_in    = s1_tvalid && s1_tready[0];
      acc_out   = m1_tvalid && m1_tready;
      if (acc_out) begin
        check("ovr_out_data", m1_tdata, beat_data(300 + rcvd));
        rcvd++;
      end
      if (acc_in) sent++;
      @(negedge clk);
    end
    s1_tvalid = 1'b0; s1_tlast = 1'b0;
    check("ovr_all_received", DW'(rcvd), DW'(40));
    check("ovr_occ_empty", DW'(occ1), DW'(0));

    // ---- back in ST_STORE: a partial packet must be held back ----
    m1_tready = 1'b1;
    s1_tvalid = 1'b1; s1_tdata = beat_data(500); s1_tlast = 1'b0;
    @(negedge clk);
    check("post_ovr_hold", DW'(m1_tvalid), DW'(0));
    s1_tdata = beat_data(501); s1_tlast = 1'b1;
    @(negedge clk);
    s1_tvalid = 1'b0; s1_tlast = 1'b0;
    check("post_ovr_release", DW'(m1_tvalid), DW'(1));
    check("post_ovr_data", m1_tdata, beat_data(500));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
